// File: rtl/window_gen_pkg.sv
// window_gen_pkg: shared types and default sizes for the window generator.
// Holds the run-state enum and the default counter width / channel count.
package window_gen_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int DEF_CNT_W  = 32;
   localparam int DEF_NUM_CH = 2;

endpackage

// File: rtl/window_gen_chan.sv
// window_gen_chan: one window channel with shadow ON/OFF counts, compare and
// set/clear flop. Ports: clk, rst (async high), cap_i (shadow capture strobe),
// run_i (evaluate this cycle), clr_i (force window low), cnt_i (frame counter),
// on_i/off_i (live counts), win_o (registered window).
// With WINDOW_GEN_CFG_CHECK_EN: period_i (live period), err_o (cfg error flag).
module window_gen_chan
   import window_gen_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cap_i,
   input  logic             run_i,
   input  logic             clr_i,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic [CNT_W-1:0] on_i,
   input  logic [CNT_W-1:0] off_i,
`ifdef WINDOW_GEN_CFG_CHECK_EN
   input  logic [CNT_W-1:0] period_i,
   output logic             err_o,
`endif
   output logic             win_o
);

   logic [CNT_W-1:0] on_q;
   logic [CNT_W-1:0] off_q;
   logic             win_q;
   logic             win_d;
   logic             blk;

`ifdef WINDOW_GEN_CFG_CHECK_EN
   logic err_q;
   logic bad;

   // Judged on the live inputs so the flag lands with the shadow copy.
   assign bad   = (on_i >= off_i) || (off_i > period_i);
   assign blk   = err_q;
   assign err_o = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (cap_i) begin
         err_q <= bad;
      end
   end
`else
   assign blk = 1'b0;
`endif

   // Clear beats everything; OFF beats ON on the same count.
   always_comb begin
      win_d = win_q;
      if (clr_i) begin
         win_d = 1'b0;
      end else if (run_i) begin
         if (cnt_i == off_q) begin
            win_d = 1'b0;
         end else if ((cnt_i == on_q) && !blk) begin
            win_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         on_q  <= '0;
         off_q <= '0;
         win_q <= 1'b0;
      end else begin
         if (cap_i) begin
            on_q  <= on_i;
            off_q <= off_i;
         end
         win_q <= win_d;
      end
   end

   assign win_o = win_q;

endmodule

// File: rtl/window_gen.sv
// window_gen: shared frame counter + IDLE/RUN control driving NUM_CH windows.
// Ports: clk, rst (async high), en, mode (0 periodic / 1 one-shot), start,
// period, ch_on, ch_off (packed per channel), win_out, frame_done, busy.
// Option WINDOW_GEN_CFG_CHECK_EN adds cfg_err (per-channel config error).
module window_gen
   import window_gen_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int NUM_CH = DEF_NUM_CH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    mode,
   input  logic                    start,
   input  logic [CNT_W-1:0]        period,
   input  logic [NUM_CH*CNT_W-1:0] ch_on,
   input  logic [NUM_CH*CNT_W-1:0] ch_off,
   output logic [NUM_CH-1:0]       win_out,
   output logic                    frame_done,
`ifdef WINDOW_GEN_CFG_CHECK_EN
   output logic [NUM_CH-1:0]       cfg_err,
`endif
   output logic                    busy
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] period_q;
   logic             mode_q;
   logic             fdone_q;

   logic launch;
   logic run_ok;
   logic fend;
   logic abort;
   logic cap;
   logic clr;

   always_comb begin
      launch = (state_q == IDLE) && en && (!mode || start);
      run_ok = (state_q == RUN) && en;
      fend   = run_ok && (cnt_q == period_q);
      abort  = (state_q == RUN) && !en;
      // Shadows refresh on launch and on every periodic frame wrap.
      cap    = launch || (fend && !mode_q);
      clr    = abort || fend;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         period_q <= '0;
         mode_q   <= 1'b0;
         fdone_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_q   <= '0;
               fdone_q <= 1'b0;
               if (launch) begin
                  state_q  <= RUN;
                  period_q <= period;
                  mode_q   <= mode;
               end
            end
            RUN: begin
               if (!en) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  fdone_q <= 1'b0;
               end else if (cnt_q == period_q) begin
                  fdone_q <= 1'b1;
                  cnt_q   <= '0;
                  if (mode_q) begin
                     state_q <= IDLE;
                  end else begin
                     period_q <= period;
                     mode_q   <= mode;
                  end
               end else begin
                  fdone_q <= 1'b0;
                  cnt_q   <= cnt_q + ONE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      window_gen_chan #(
         .CNT_W(CNT_W)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .cap_i   (cap),
         .run_i   (run_ok),
         .clr_i   (clr),
         .cnt_i   (cnt_q),
         .on_i    (ch_on[i*CNT_W +: CNT_W]),
         .off_i   (ch_off[i*CNT_W +: CNT_W]),
`ifdef WINDOW_GEN_CFG_CHECK_EN
         .period_i(period),
         .err_o   (cfg_err[i]),
`endif
         .win_o   (win_out[i])
      );
   end

   assign frame_done = fdone_q;
   assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: randomized + directed bench for window_gen with a
// frame-position reference model feeding a scoreboard queue.
module tb_window_gen;

   localparam int W = 32;
   localparam int N = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           en = 1'b0;
   logic           mode = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   period = '0;
   logic [N*W-1:0] ch_on = '0;
   logic [N*W-1:0] ch_off = '0;
   logic [N-1:0]   win_out;
   logic           frame_done;
   logic           busy;
`ifdef WINDOW_GEN_CFG_CHECK_EN
   logic [N-1:0]   cfg_err;
`endif

   window_gen #(.CNT_W(W), .NUM_CH(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode),
      .start     (start),
      .period    (period),
      .ch_on     (ch_on),
      .ch_off    (ch_off),
      .win_out   (win_out),
      .frame_done(frame_done),
`ifdef WINDOW_GEN_CFG_CHECK_EN
      .cfg_err   (cfg_err),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0] win;
      logic         fd;
      logic         busy;
      logic [N-1:0] err;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   // Reference model: frame position plus the configuration of the frame.
   bit          m_run = 0;
   int unsigned m_pos = 0;
   int unsigned m_per = 0;
   bit          m_mode = 0;
   bit          m_fd = 0;
   int unsigned m_on[N];
   int unsigned m_off[N];
   bit [N-1:0]  m_err = '0;

   function automatic void capture();
      m_per  = period;
      m_mode = mode;
      for (int i = 0; i < N; i++) begin
         m_on[i]  = ch_on[i*W +: W];
         m_off[i] = ch_off[i*W +: W];
         m_err[i] = (m_on[i] >= m_off[i]) || (m_off[i] > m_per);
      end
   endfunction

   // Window at position p: opened by an ON strictly before p and not yet
   // closed by an OFF in [ON, p-1] (OFF == ON means never opened).
   function automatic exp_t predict();
      exp_t e;
      e.busy = m_run;
      e.fd   = m_fd;
      e.err  = m_err;
      for (int i = 0; i < N; i++) begin
         e.win[i] = m_run && (m_on[i] < m_pos) &&
                    ((m_off[i] < m_on[i]) || (m_off[i] >= m_pos));
`ifdef WINDOW_GEN_CFG_CHECK_EN
         if (m_err[i]) e.win[i] = 1'b0;
`endif
      end
      return e;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run = 0; m_pos = 0; m_per = 0; m_mode = 0; m_fd = 0; m_err = '0;
         for (int i = 0; i < N; i++) begin
            m_on[i] = 0; m_off[i] = 0;
         end
      end else begin
         if (!m_run) begin
            m_fd = 0; m_pos = 0;
            if (en && (!mode || start)) begin
               capture();
               m_run = 1;
            end
         end else if (!en) begin
            m_run = 0; m_pos = 0; m_fd = 0;
         end else if (m_pos == m_per) begin
            m_fd = 1; m_pos = 0;
            if (m_mode) m_run = 0;
            else capture();
         end else begin
            m_pos++;
            m_fd = 0;
         end
         q.push_back(predict());
      end
   end

   // Monitor: one expected entry per clock edge outside reset.
   always @(posedge clk) begin
      exp_t e;
      logic ok;
      #1;
      if (!rst) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL sb_empty t=%0t", $time);
         end else begin
            e  = q.pop_front();
            ok = (win_out === e.win) && (frame_done === e.fd) &&
                 (busy === e.busy);
`ifdef WINDOW_GEN_CFG_CHECK_EN
            ok = ok && (cfg_err === e.err);
`endif
            if (!ok) begin
               bad++;
               if (bad < 30)
                  $display("FAIL cycle t=%0t got win=%b fd=%b busy=%b want win=%b fd=%b busy=%b",
                           $time, win_out, frame_done, busy, e.win, e.fd, e.busy);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, expv);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ch(input int i, input int unsigned on, input int unsigned off);
      ch_on[i*W +: W]  = W'(on);
      ch_off[i*W +: W] = W'(off);
   endtask

   task automatic go_idle();
      en = 1'b0;
      start = 1'b0;
      cyc(2);
   endtask

   task automatic oneshot(output int nb, output int nw, output int nf);
      nb = 0; nw = 0; nf = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         nb += int'(busy);
         nw += int'(win_out[0]);
         nf += int'(frame_done);
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int c0, c1, cf, nb, nw, nf;
      bit seen;
      #1;
      chk("reset_out", int'({win_out, frame_done, busy}), 0);
      @(negedge clk);
      rst = 1'b0;
      cyc(2);
      chk("idle_busy", int'(busy), 0);

      // Periodic, period 75.
      period = 75; mode = 1'b0;
      set_ch(0, 15, 35); set_ch(1, 50, 75);
      en = 1'b1;
      c0 = 0; c1 = 0; cf = 0;
      for (int k = 1; k <= 160; k++) begin
         @(negedge clk);
         if (k <= 76) begin
            c0 += int'(win_out[0]);
            c1 += int'(win_out[1]);
         end
         cf += int'(frame_done);
      end
      chk("per_win0_len", c0, 20);
      chk("per_win1_len", c1, 25);
      chk("per_fd_count", cf, 2);
      go_idle();

      // One-shot, period 10, twice.
      period = 10; mode = 1'b1;
      set_ch(0, 2, 5); set_ch(1, 20, 30);
      en = 1'b1;
      oneshot(nb, nw, nf);
      chk("os_busy_len", nb, 11);
      chk("os_win_len", nw, 3);
      chk("os_fd_count", nf, 1);
      oneshot(nb, nw, nf);
      chk("os2_busy_len", nb, 11);
      chk("os2_win_len", nw, 3);
      go_idle();

      // Mid-frame reconfiguration.
      period = 20; mode = 1'b0;
      set_ch(0, 2, 8); set_ch(1, 40, 50);
      en = 1'b1;
      c0 = 0; c1 = 0;
      for (int k = 1; k <= 42; k++) begin
         @(negedge clk);
         if (k == 7) set_ch(0, 4, 8);
         if (k <= 21) c0 += int'(win_out[0]);
         else c1 += int'(win_out[0]);
      end
      chk("recfg_cur", c0, 6);
      chk("recfg_next", c1, 4);
      go_idle();

      // en dropped at counter 30 with window open.
      period = 75; set_ch(0, 15, 35);
      en = 1'b1;
      cyc(31);
      chk("abort_open", int'(win_out[0]), 1);
      en = 1'b0;
      @(negedge clk);
      chk("abort_out", int'({win_out, frame_done, busy}), 0);
      cyc(1);

      // Boundaries: ON==OFF, ON==period, then period 0.
      period = 12; set_ch(0, 5, 5); set_ch(1, 12, 20);
      en = 1'b1;
      c0 = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         c0 += int'(win_out != '0);
      end
      chk("bnd_never", c0, 0);
      go_idle();
      period = 0; set_ch(0, 0, 3); set_ch(1, 0, 0);
      en = 1'b1;
      cyc(2);
      cf = 0; c0 = 0;
      for (int k = 0; k < 20; k++) begin
         cf += int'(frame_done);
         c0 += int'(win_out != '0);
         @(negedge clk);
      end
      chk("p0_fd_high", cf, 20);
      chk("p0_no_win", c0, 0);
      go_idle();

`ifdef WINDOW_GEN_CFG_CHECK_EN
      period = 20; mode = 1'b0;
      set_ch(0, 9, 3); set_ch(1, 2, 6);
      en = 1'b1;
      c0 = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         c0 += int'(win_out[0]);
      end
      chk("cfg_err0", int'(cfg_err), 1);
      chk("cfg_hold0", c0, 0);
      go_idle();
`endif

      // Random traffic, scoreboard only.
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if ($urandom_range(0, 29) == 0) en = ~en;
         else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
         if ($urandom_range(0, 15) == 0) mode = $urandom_range(0, 1) != 0;
         start = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 9) == 0) period = W'($urandom_range(0, 15));
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 7) == 0)
               set_ch(i, $urandom_range(0, 18), $urandom_range(0, 18));
      end
      go_idle();

      // Async reset in the middle of an open window.
      period = 30; mode = 1'b0;
      set_ch(0, 3, 20); set_ch(1, 5, 25);
      en = 1'b1;
      seen = 0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         seen = win_out[0];
      end
      chk("arst_win_seen", int'(seen), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out", int'({win_out, frame_done, busy}), 0);
      @(negedge clk);
      en = 1'b0;
      rst = 1'b0;
      cyc(2);
      chk("arst_idle", int'(busy), 0);

      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
